// File: rtl/seg_scan_display.sv
// Multiplexed 7-segment scanner: double-buffered digit data, live dash mask and per-digit blink.
// digit_sel/seg are registered and change together with the scan pointer.
module seg_scan_display #(
  parameter int NUM_DIGITS   = 4,
  parameter int DIV          = 12500,
  parameter int BLINK_FRAMES = 50
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    load,
  input  logic [4*NUM_DIGITS-1:0] digits_in,
  input  logic [NUM_DIGITS-1:0]   valid_in,
  input  logic [NUM_DIGITS-1:0]   dp_in,
  input  logic [NUM_DIGITS-1:0]   blink_en,
  input  logic                    mask,
  output logic [NUM_DIGITS-1:0]   digit_sel,
  output logic [7:0]              seg,
  output logic                    frame_done
);

  localparam int DW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int PW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam int BW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

  localparam logic [DW-1:0] DIV_LAST   = DW'(DIV - 1);
  localparam logic [PW-1:0] POS_LAST   = PW'(NUM_DIGITS - 1);
  localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_FRAMES - 1);

  typedef struct packed {
    logic [4*NUM_DIGITS-1:0] digits;
    logic [NUM_DIGITS-1:0]   valid;
    logic [NUM_DIGITS-1:0]   dp;
    logic [NUM_DIGITS-1:0]   blink;
  } frame_buf_t;

  function automatic logic [6:0] hex7(input logic [3:0] n);
    logic [6:0] s;
    case (n)
      4'h0: s = 7'h3F;  4'h1: s = 7'h06;  4'h2: s = 7'h5B;  4'h3: s = 7'h4F;
      4'h4: s = 7'h66;  4'h5: s = 7'h6D;  4'h6: s = 7'h7D;  4'h7: s = 7'h07;
      4'h8: s = 7'h7F;  4'h9: s = 7'h6F;  4'hA: s = 7'h77;  4'hB: s = 7'h7C;
      4'hC: s = 7'h39;  4'hD: s = 7'h5E;  4'hE: s = 7'h79;  default: s = 7'h71;
    endcase
    return s;
  endfunction

  logic [DW-1:0] div_cnt;
  logic [PW-1:0] pos, pos_n;
  logic [BW-1:0] blink_cnt, blink_cnt_n;
  logic          blink_phase, blink_phase_n;
  frame_buf_t    pend, pend_n, act, act_n, incoming;
  logic          tick, wrap, lit;
  logic [3:0]    nib;
  logic [NUM_DIGITS-1:0] sel_n;
  logic [7:0]    seg_n;

  assign incoming = '{digits: digits_in, valid: valid_in, dp: dp_in, blink: blink_en};
  assign tick     = (div_cnt == DIV_LAST);
  assign wrap     = tick && (pos == POS_LAST);

  // Outputs are decoded from next-state values so they move on the same edge as pos.
  always_comb begin
    pend_n        = load ? incoming : pend;
    act_n         = wrap ? pend_n : act;
    pos_n         = pos;
    blink_cnt_n   = blink_cnt;
    blink_phase_n = blink_phase;
    if (tick) pos_n = (pos == POS_LAST) ? '0 : pos + 1'b1;
    if (wrap) begin
      if (blink_cnt == BLINK_LAST) begin
        blink_cnt_n   = '0;
        blink_phase_n = ~blink_phase;
      end else begin
        blink_cnt_n = blink_cnt + 1'b1;
      end
    end

    nib   = act_n.digits[pos_n*4 +: 4];
    lit   = act_n.valid[pos_n] && !(blink_phase_n && act_n.blink[pos_n]);
    sel_n = '1;
    seg_n = 8'h00;
    if (lit) begin
      sel_n[pos_n] = 1'b0;
      seg_n        = {act_n.dp[pos_n], mask ? 7'h40 : hex7(nib)};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div_cnt     <= '0;
      pos         <= '0;
      blink_cnt   <= '0;
      blink_phase <= 1'b0;
      pend        <= '0;
      act         <= '0;
      digit_sel   <= '1;
      seg         <= 8'h00;
      frame_done  <= 1'b0;
    end else begin
      div_cnt     <= tick ? '0 : div_cnt + 1'b1;
      pos         <= pos_n;
      blink_cnt   <= blink_cnt_n;
      blink_phase <= blink_phase_n;
      pend        <= pend_n;
      act         <= act_n;
      digit_sel   <= sel_n;
      seg         <= seg_n;
      frame_done  <= wrap;
    end
  end

endmodule

// File: tb/tb_seg_scan_display.sv
// Directed bench for seg_scan_display with DIV=4, BLINK_FRAMES=2, NUM_DIGITS=4.
module tb_seg_scan_display;

  logic        clk;
  logic        rst_n;
  logic        load;
  logic [15:0] digits_in;
  logic [3:0]  valid_in;
  logic [3:0]  dp_in;
  logic [3:0]  blink_en;
  logic        mask;
  logic [3:0]  digit_sel;
  logic [7:0]  seg;
  logic        frame_done;

  int n_chk  = 0;
  int n_fail = 0;

  seg_scan_display #(.NUM_DIGITS(4), .DIV(4), .BLINK_FRAMES(2)) dut (
    .clk(clk), .rst_n(rst_n), .load(load), .digits_in(digits_in),
    .valid_in(valid_in), .dp_in(dp_in), .blink_en(blink_en), .mask(mask),
    .digit_sel(digit_sel), .seg(seg), .frame_done(frame_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Checks the 15 cycles between reset release and the first frame wrap.
  task automatic run_dark();
    for (int i = 1; i < 16; i++) begin
      @(negedge clk);
      load = 1'b0;
      chk($sformatf("dark c%0d sel", i), {4'h0, digit_sel}, 8'h0F);
      chk($sformatf("dark c%0d seg", i), seg, 8'h00);
      chk($sformatf("dark c%0d fd", i), {7'h0, frame_done}, 8'h00);
    end
  endtask

  // One full frame (4 slots x 4 cycles); optional load issued in cycle ld_at.
  task automatic run_frame(input int f,
                           input logic [7:0] s0, input logic [7:0] s1,
                           input logic [7:0] s2, input logic [7:0] s3,
                           input logic [3:0] lit, input int ld_at,
                           input logic [15:0] nd, input logic [3:0] nv,
                           input logic [3:0] ndp, input logic [3:0] nbl,
                           input logic nmask);
    logic [7:0] s [4];
    logic [3:0] esel;
    logic [7:0] eseg;
    int p;
    s[0] = s0; s[1] = s1; s[2] = s2; s[3] = s3;
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      load = 1'b0;
      p    = i / 4;
      esel = lit[p] ? ~(4'b0001 << p) : 4'hF;
      eseg = lit[p] ? s[p] : 8'h00;
      chk($sformatf("f%0d c%0d sel", f, i), {4'h0, digit_sel}, {4'h0, esel});
      chk($sformatf("f%0d c%0d seg", f, i), seg, eseg);
      chk($sformatf("f%0d c%0d fd", f, i), {7'h0, frame_done}, (i == 0) ? 8'h01 : 8'h00);
      if (i == ld_at) begin
        load      = 1'b1;
        digits_in = nd;
        valid_in  = nv;
        dp_in     = ndp;
        blink_en  = nbl;
        mask      = nmask;
      end
    end
  endtask

  initial begin
    rst_n = 1'b0; load = 1'b0; digits_in = '0; valid_in = '0;
    dp_in = '0; blink_en = '0; mask = 1'b0;
    repeat (3) @(negedge clk);
    chk("reset sel", {4'h0, digit_sel}, 8'h0F);
    chk("reset seg", seg, 8'h00);
    chk("reset fd", {7'h0, frame_done}, 8'h00);

    // Load 4321 on the first cycle after release; nothing shows until the wrap.
    digits_in = 16'h4321; valid_in = 4'hF; load = 1'b1;
    rst_n = 1'b1;
    run_dark();
    run_frame(1, 8'h06, 8'h5B, 8'h4F, 8'h66, 4'hF, -1, '0, '0, '0, '0, 1'b0);
    // Mid-frame load at pos 1 must not tear the current frame.
    run_frame(2, 8'h06, 8'h5B, 8'h4F, 8'h66, 4'hF, 5, 16'h5678, 4'hF, 4'h0, 4'h0, 1'b0);
    // Load on the wrap tick itself, together with mask.
    run_frame(3, 8'h7F, 8'h07, 8'h7D, 8'h6D, 4'hF, 15, 16'h9A3C, 4'b0101, 4'h0, 4'h0, 1'b1);
    run_frame(4, 8'h40, 8'h00, 8'h40, 8'h00, 4'b0101, 15, 16'h3218, 4'hF, 4'b0001, 4'b0001, 1'b0);
    // Blink phase: frames 5 on, 6-7 off, 8-9 on for digit 0 only.
    run_frame(5, 8'hFF, 8'h06, 8'h5B, 8'h4F, 4'hF, -1, '0, '0, '0, '0, 1'b0);
    run_frame(6, 8'h00, 8'h06, 8'h5B, 8'h4F, 4'hE, -1, '0, '0, '0, '0, 1'b0);
    run_frame(7, 8'h00, 8'h06, 8'h5B, 8'h4F, 4'hE, -1, '0, '0, '0, '0, 1'b0);
    run_frame(8, 8'hFF, 8'h06, 8'h5B, 8'h4F, 4'hF, -1, '0, '0, '0, '0, 1'b0);
    run_frame(9, 8'hFF, 8'h06, 8'h5B, 8'h4F, 4'hF, -1, '0, '0, '0, '0, 1'b0);

    // Frame 10: digit 1 lit, then asynchronous reset between clock edges.
    repeat (5) @(negedge clk);
    chk("pre-rst sel", {4'h0, digit_sel}, 8'h0D);
    chk("pre-rst seg", seg, 8'h06);
    #2 rst_n = 1'b0;
    #1;
    chk("async rst sel", {4'h0, digit_sel}, 8'h0F);
    chk("async rst seg", seg, 8'h00);
    chk("async rst fd", {7'h0, frame_done}, 8'h00);
    @(negedge clk);
    load = 1'b0;
    rst_n = 1'b1;
    run_dark();
    // Stays dark across the first wrap; a load then lights the next frame.
    run_frame(11, 8'h00, 8'h00, 8'h00, 8'h00, 4'h0, 8, 16'h00FE, 4'b0011, 4'h0, 4'h0, 1'b0);
    run_frame(12, 8'h79, 8'h71, 8'h00, 8'h00, 4'b0011, -1, '0, '0, '0, '0, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
